// File: rtl/data_bus_arbiter_4_if.sv
// data_bus_arbiter_4_if: core request/ack and memory port bundle for the four-core arbiter
interface data_bus_arbiter_4_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [3:0]          req_i;
  logic [3:0]          we_i;
  logic [4*ADDR_W-1:0] addr_i;
  logic [4*DATA_W-1:0] wdata_i;
  logic [3:0]          ack_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                mem_en_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    input  ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    output ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/data_bus_arbiter_4.sv
// data_bus_arbiter_4: round-robin 4-core arbiter onto one memory port; MEM_WINDOW_EN confines core k to window k
module data_bus_arbiter_4 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  data_bus_arbiter_4_if.slave b
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, g, g_n, pick;
  logic hit;
  logic [3:0] ack, ack_n;
  logic en, en_n, we, we_n;
  logic [ADDR_W-1:0] addr, addr_n, sel_addr;
  logic [DATA_W-1:0] wd, wd_n;
`ifdef MEM_WINDOW_EN
  assign sel_addr = {pick, b.addr_i[pick*ADDR_W +: ADDR_W-2]};
`else
  assign sel_addr = b.addr_i[pick*ADDR_W +: ADDR_W];
`endif
  // first requesting core at or above ptr, wrapping modulo 4
  always_comb begin
    pick = ptr;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!hit && b.req_i[ptr + 2'(i)]) begin
        pick = ptr + 2'(i);
        hit = 1'b1;
      end
  end
  // next-state and registered-output values
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    g_n = g;
    ack_n = ack;
    en_n = en;
    we_n = we;
    addr_n = addr;
    wd_n = wd;
    if (state == IDLE && hit) begin
      state_n = ACCESS;
      g_n = pick;
      en_n = 1'b1;
      we_n = b.we_i[pick];
      addr_n = sel_addr;
      wd_n = b.wdata_i[pick*DATA_W +: DATA_W];
    end else if (state == ACCESS) begin
      state_n = RESP;
      en_n = 1'b0;
      we_n = 1'b0;
      ack_n = 4'b0001 << g;
      ptr_n = g + 2'd1;
    end else if (state != IDLE) begin
      state_n = IDLE;
      ack_n = '0;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      ack <= '0;
      en <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      wd <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      g <= g_n;
      ack <= ack_n;
      en <= en_n;
      we <= we_n;
      addr <= addr_n;
      wd <= wd_n;
    end
  end
  assign b.ack_o = ack;
  assign b.rdata_o = |ack ? b.mem_rdata_i : '0;
  assign b.mem_en_o = en;
  assign b.mem_we_o = we;
  assign b.mem_addr_o = addr;
  assign b.mem_wdata_o = wd;
endmodule
